// File: rtl/lsu_lq_age_if.sv
// lsu_lq_age_if: issue, store-retire and ROB-retire signals of the load queue
interface lsu_lq_age_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_WIDTH  = 6,
  parameter int LQ_DEPTH   = 8
);
  logic                        i_flush;
  logic [TAG_WIDTH-1:0]        i_rob_head_tag;
  logic                        i_alloc_en;
  logic [TAG_WIDTH-1:0]        i_alloc_tag;
  logic [ADDR_WIDTH-1:0]       i_alloc_addr;
  logic [3:0]                  i_alloc_width;
  logic                        i_sq_retire_en;
  logic [TAG_WIDTH-1:0]        i_sq_retire_tag;
  logic [ADDR_WIDTH-1:0]       i_sq_retire_addr;
  logic [3:0]                  i_sq_retire_width;
  logic                        i_rob_retire_en;
  logic [TAG_WIDTH-1:0]        i_rob_retire_tag;
  logic                        o_rob_retire_mis_speculated;
  logic                        o_full;
  logic                        o_empty;
  logic [$clog2(LQ_DEPTH):0]   o_count;
  modport master (
    output i_flush, i_rob_head_tag, i_alloc_en, i_alloc_tag, i_alloc_addr, i_alloc_width,
           i_sq_retire_en, i_sq_retire_tag, i_sq_retire_addr, i_sq_retire_width,
           i_rob_retire_en, i_rob_retire_tag,
    input  o_rob_retire_mis_speculated, o_full, o_empty, o_count
  );
  modport slave (
    input  i_flush, i_rob_head_tag, i_alloc_en, i_alloc_tag, i_alloc_addr, i_alloc_width,
           i_sq_retire_en, i_sq_retire_tag, i_sq_retire_addr, i_sq_retire_width,
           i_rob_retire_en, i_rob_retire_tag,
    output o_rob_retire_mis_speculated, o_full, o_empty, o_count
  );
endinterface

// File: rtl/lsu_lq_age.sv
// lsu_lq_age: age-aware byte-accurate load queue; flags younger overlapping loads on store retire
module lsu_lq_age #(
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_WIDTH  = 6,
  parameter int LQ_DEPTH   = 8
) (
  input logic         clk,
  input logic         n_rst,
  lsu_lq_age_if.slave lq
);
  localparam int IW = $clog2(LQ_DEPTH);
  localparam int CW = IW + 1;
  logic [LQ_DEPTH-1:0]   valid, mis, hit, match;
  logic [ADDR_WIDTH-1:0] addr [LQ_DEPTH];
  logic [3:0]            width [LQ_DEPTH];
  logic [TAG_WIDTH-1:0]  tag [LQ_DEPTH];
  logic [IW-1:0]         free_idx;
  logic [CW-1:0]         count;
  logic                  alloc;
  logic [TAG_WIDTH-1:0]  store_age;
  logic [ADDR_WIDTH:0]   store_end;
  assign store_age = lq.i_sq_retire_tag - lq.i_rob_head_tag;
  assign store_end = {1'b0, lq.i_sq_retire_addr} + {{(ADDR_WIDTH-3){1'b0}}, lq.i_sq_retire_width};
  // end sums carry one extra bit so ranges touching the top of memory do not wrap
  for (genvar i = 0; i < LQ_DEPTH; i++) begin : g_slot
    logic [TAG_WIDTH-1:0] load_age;
    logic [ADDR_WIDTH:0]  load_end;
    assign load_age = tag[i] - lq.i_rob_head_tag;
    assign load_end = {1'b0, addr[i]} + {{(ADDR_WIDTH-3){1'b0}}, width[i]};
    assign hit[i]   = lq.i_sq_retire_en & valid[i] & (load_age > store_age) &
                      ({1'b0, addr[i]} < store_end) & ({1'b0, lq.i_sq_retire_addr} < load_end);
    assign match[i] = lq.i_rob_retire_en & valid[i] & (tag[i] == lq.i_rob_retire_tag);
  end
  always_comb begin
    free_idx = '0;
    count    = '0;
    for (int k = LQ_DEPTH - 1; k >= 0; k--) begin
      free_idx = valid[k] ? free_idx : IW'(k);
      count    = count + CW'(valid[k]);
    end
  end
  assign alloc = lq.i_alloc_en & ~&valid;
  assign lq.o_full  = &valid;
  assign lq.o_empty = ~|valid;
  assign lq.o_count = count;
  assign lq.o_rob_retire_mis_speculated = |(match & (mis | hit));
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      valid <= '0;
      mis   <= '0;
    end else if (lq.i_flush) begin
      valid <= '0;
      mis   <= '0;
    end else begin
      for (int k = 0; k < LQ_DEPTH; k++)
        if (alloc && free_idx == IW'(k)) begin
          valid[k] <= 1'b1;
          mis[k]   <= 1'b0;
        end else begin
          if (hit[k]) mis[k] <= 1'b1;
          if (match[k]) valid[k] <= 1'b0;
        end
    end
  always_ff @(posedge clk)
    if (alloc && !lq.i_flush) begin
      addr[free_idx]  <= lq.i_alloc_addr;
      width[free_idx] <= lq.i_alloc_width;
      tag[free_idx]   <= lq.i_alloc_tag;
    end
endmodule

// File: doc/lsu_lq_age.md
# lsu_lq_age

Age-aware, byte-accurate load queue for the LSU. Holds every issued load, with address, byte width and ROB tag, until the ROB retires it. On each retiring store it flags only those loads that are younger than the store and whose byte range overlaps the store's. At load retirement it tells the ROB whether the load must be replayed. It sits between LSU issue (allocation), the store queue (retire broadcast) and the ROB (retire/head tag).

## Interface
- ADDR_WIDTH, 32, load/store byte address width
- TAG_WIDTH, 6, ROB tag width; tags wrap modulo 2^TAG_WIDTH
- LQ_DEPTH, 8, number of slots; power of two, 2..64
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- i_flush  in  1  invalidate all slots
- i_rob_head_tag  in  TAG_WIDTH  tag of oldest in-flight ROB entry, the age reference
- i_alloc_en  in  1  allocate a load this cycle
- i_alloc_tag  in  TAG_WIDTH  ROB tag of the load
- i_alloc_addr  in  ADDR_WIDTH  load byte address
- i_alloc_width  in  4  load size in bytes (1, 2, 4 or 8)
- i_sq_retire_en  in  1  a store is retiring
- i_sq_retire_tag  in  TAG_WIDTH  ROB tag of the retiring store
- i_sq_retire_addr  in  ADDR_WIDTH  store byte address
- i_sq_retire_width  in  4  store size in bytes
- i_rob_retire_en  in  1  a load is retiring
- i_rob_retire_tag  in  TAG_WIDTH  ROB tag of the retiring load
- o_rob_retire_mis_speculated  out  1  retiring load must be replayed
- o_full  out  1  no free slot
- o_empty  out  1  no valid slot
- o_count  out  $clog2(LQ_DEPTH)+1  number of valid slots

## Operation
- Slot state: valid, addr, width, tag, mis_speculated.
- Reset values:
  - All valid = 0 and mis_speculated = 0.
  - o_full = 0, o_empty = 1, o_count = 0, o_rob_retire_mis_speculated = 0.
- Allocation:
  - Requires i_alloc_en and !o_full.
  - Takes the lowest-index invalid slot, chosen from the pre-edge valid set.
  - Writes addr, width and tag, and sets valid = 1 and mis_speculated = 0.
  - i_alloc_en while full is ignored: no state change.
- Age: age(x) = (x - i_rob_head_tag) mod 2^TAG_WIDTH, in TAG_WIDTH-bit unsigned arithmetic. A load is younger than the store iff age(load.tag) > age(store.tag).
- Overlap:
  - Load range is [la, la+lw); store range is [sa, sa+sw).
  - The ranges overlap iff la < sa+sw and sa < la+lw.
  - End sums are computed in ADDR_WIDTH+1 bits, so a range touching the top of memory does not wrap.
- Store check:
  - On i_sq_retire_en, every valid slot that is younger and overlapping sets mis_speculated = 1.
  - Older and non-overlapping slots are untouched.
- Retire:
  - On i_rob_retire_en, the valid slot with tag == i_rob_retire_tag clears valid at the edge. At most one slot matches.
  - If no slot matches: no state change, and o_rob_retire_mis_speculated = 0.
- o_rob_retire_mis_speculated:
  - Asserted when i_rob_retire_en is high and the matched slot has mis_speculated = 1.
  - Also asserted when a store retiring the same cycle would flag that slot (bypass).
- Flush: i_flush clears every valid bit. It takes priority over allocate, retire and store-check in the same cycle.

## Timing
- Allocation, retire, flush and mis_speculated updates take effect at the rising clk edge.
- o_rob_retire_mis_speculated is combinational from the current inputs and slot state, so it is valid in the same cycle as i_rob_retire_en.
- o_full, o_empty and o_count are registered-state derived. They reflect allocations and retires one cycle after the requesting cycle.
- Allocate and retire in the same cycle, not full: both occur. Count is unchanged.
- Allocate and retire in the same cycle, full: the allocation is dropped, because the freed slot is not visible until the next cycle. Upstream must gate on o_full.
- Allocate and store-check in the same cycle: the newly allocated entry ends with mis_speculated = 0. The store is not checked against it.
- Store-check and retire on the same slot: the slot is freed, and o_rob_retire_mis_speculated uses the bypass.
- Asynchronous reset mid-operation: all slots invalid immediately. Outputs return to reset values without waiting for clk.

## Test plan
- **Reset, then fill:** reset, then 8 allocs with tags 0..7 → o_count 8, o_full 1. A 9th alloc is dropped and the count stays 8.
- **Partial overlap:** head 0; alloc load tag 5, addr 0x100, width 4; store retire tag 3, addr 0x102, width 2; retire tag 5 → mis_speculated 1.
- **Older load:** same addresses, load tag 2 and store tag 3 → mis_speculated 0. Adjacent ranges (load 0x100 width 4, store 0x104 width 4) → 0.
- **Wrap-around age:** head 60, TAG_WIDTH 6, load tag 1, store tag 62, overlapping ranges → load flagged, since age 5 > 2.
- **Same-cycle bypass:** store retire and load retire (tag 5, overlapping) in one cycle → mis_speculated 1, slot freed.
- **Flush and reset:** flush with 3 valid slots → o_empty 1 next cycle. Assert n_rst mid-stream → outputs reset immediately, without a clk edge. Retire of an absent tag → output 0, no change.
